config_chain_scheduler: RTL and testbench



---
 rtl/config_chain_scheduler.sv | 153 +++++++++++++++
 tb/tb_config_chain_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_scheduler.sv
// config_chain_scheduler
// Loads a serial configuration chain of CHAIN_LEN bits from host words of
// WORD_W bits. Each accepted word is unpacked LSB first onto ccff_head with a
// matching ccff_shift_en strobe. Bits of the last word beyond CHAIN_LEN are
// dropped. A load ends in a one-cycle done pulse, or in a one-cycle aborted
// pulse when abort is raised during shifting.
//
// Ports
//   clk           : clock, rising edge
//   Reset         : asynchronous reset, active low
//   start         : begin a load (honoured in IDLE only)
//   abort         : abandon a load in progress (honoured in SHIFT only)
//   cfg_valid     : host word available
//   cfg_data      : host word, bit 0 shifted first
//   cfg_ready     : word accepted this cycle when cfg_valid is also high
//                   (combinational from registered state)
//   ccff_head     : serial data into the chain head (registered)
//   ccff_shift_en : chain shift strobe (registered)
//   busy          : any state other than IDLE (registered)
//   done          : one-cycle pulse on successful completion (registered)
//   aborted       : one-cycle pulse when a load is abandoned (registered)
module config_chain_scheduler #(
  parameter int unsigned CHAIN_LEN = 60,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int unsigned NWORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned BIT_CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WORD_CNT_W = $clog2(NWORDS + 1);
  localparam int unsigned BUF_CNT_W  = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_n;   // bits presented on ccff_head
  logic [BIT_CNT_W-1:0]  acc_cnt, acc_cnt_n;   // valid bits accepted from host
  logic [WORD_CNT_W-1:0] word_cnt, word_cnt_n;
  logic [WORD_W-1:0]     shreg, shreg_n;       // bits of current word not yet presented
  logic [BUF_CNT_W-1:0]  buf_cnt, buf_cnt_n;   // valid bits left in shreg
  logic                  head_n, shift_en_n;
  logic                  busy_n, done_n, aborted_n;
  int unsigned           remaining, take;

  // The buffer's last bit is already on ccff_head when buf_cnt is zero, so a
  // new word can be taken on the edge that shifts that bit out.
  assign cfg_ready = (state == SHIFT) && (32'(word_cnt) < NWORDS) && (buf_cnt == '0);

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    acc_cnt_n  = acc_cnt;
    word_cnt_n = word_cnt;
    shreg_n    = shreg;
    buf_cnt_n  = buf_cnt;
    head_n     = ccff_head;
    shift_en_n = 1'b0;
    remaining  = CHAIN_LEN - 32'(acc_cnt);
    take       = (remaining < WORD_W) ? remaining : WORD_W;

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = SHIFT;
          bit_cnt_n  = '0;
          acc_cnt_n  = '0;
          word_cnt_n = '0;
          buf_cnt_n  = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n   = ABORT;
          buf_cnt_n = '0;
        end else if (buf_cnt != '0) begin
          head_n     = shreg[0];
          shreg_n    = shreg >> 1;
          buf_cnt_n  = buf_cnt - BUF_CNT_W'(1);
          shift_en_n = 1'b1;
        end else if (cfg_valid && cfg_ready) begin
          // Only `take` bits of the word are valid; the rest never leave shreg.
          head_n     = cfg_data[0];
          shreg_n    = cfg_data >> 1;
          buf_cnt_n  = BUF_CNT_W'(take - 32'd1);
          acc_cnt_n  = BIT_CNT_W'(32'(acc_cnt) + take);
          word_cnt_n = word_cnt + WORD_CNT_W'(1);
          shift_en_n = 1'b1;
        end
        if (shift_en_n) begin
          bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
          if (32'(bit_cnt) + 32'd1 == CHAIN_LEN) begin
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      ABORT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n    = (state_n != IDLE);
    done_n    = (state_n == DONE);
    aborted_n = (state_n == ABORT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      acc_cnt       <= '0;
      word_cnt      <= '0;
      shreg         <= '0;
      buf_cnt       <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      acc_cnt       <= acc_cnt_n;
      word_cnt      <= word_cnt_n;
      shreg         <= shreg_n;
      buf_cnt       <= buf_cnt_n;
      ccff_head     <= head_n;
      ccff_shift_en <= shift_en_n;
      busy          <= busy_n;
      done          <= done_n;
      aborted       <= aborted_n;
    end
  end

endmodule

// File: tb/tb_config_chain_scheduler.sv
// Randomized bench for config_chain_scheduler against a queue-based reference
// model, plus a directed run of a 5-bit chain instance.
module tb_config_chain_scheduler;

  localparam int unsigned L  = 60;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = (L + W - 1) / W;

  logic         clk = 1'b0;
  logic         Reset;
  logic         start, abort, cfg_valid;
  logic [W-1:0] cfg_data;
  logic         cfg_ready, ccff_head, ccff_shift_en, busy, done, aborted;

  logic         start_s, abort_s, valid_s;
  logic [7:0]   data_s;
  logic         ready_s, head_s, shift_s, busy_s, done_s, aborted_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  config_chain_scheduler #(.CHAIN_LEN(L), .WORD_W(W)) u_dut (
    .clk(clk), .Reset(Reset), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en),
    .busy(busy), .done(done), .aborted(aborted)
  );

  config_chain_scheduler #(.CHAIN_LEN(5), .WORD_W(8)) u_small (
    .clk(clk), .Reset(Reset), .start(start_s), .abort(abort_s),
    .cfg_valid(valid_s), .cfg_data(data_s), .cfg_ready(ready_s),
    .ccff_head(head_s), .ccff_shift_en(shift_s),
    .busy(busy_s), .done(done_s), .aborted(aborted_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: load state as a mode number plus a queue of bits still
  // to be presented on the chain head.
  localparam int M_IDLE = 0, M_SHIFT = 1, M_DONE = 2, M_ABORT = 3;
  int m_mode;
  bit mq[$];
  bit m_head, m_sh, m_busy, m_done, m_ab;
  int m_words, m_acc, m_shifted;

  task automatic model_reset();
    m_mode = M_IDLE; mq.delete();
    m_head = 0; m_sh = 0; m_busy = 0; m_done = 0; m_ab = 0;
    m_words = 0; m_acc = 0; m_shifted = 0;
  endtask

  function automatic bit model_ready();
    return (m_mode == M_SHIFT) && (m_words < int'(NW)) && (mq.size() == 0);
  endfunction

  task automatic model_edge();
    bit rdy;
    int n;
    rdy  = model_ready();
    m_sh = 0;
    case (m_mode)
      M_IDLE: if (start) begin
        m_mode = M_SHIFT; m_words = 0; m_acc = 0; m_shifted = 0; mq.delete();
      end
      M_SHIFT: begin
        if (abort) begin
          m_mode = M_ABORT; mq.delete();
        end else begin
          if (rdy && cfg_valid) begin
            n = (int'(L) - m_acc < int'(W)) ? int'(L) - m_acc : int'(W);
            for (int i = 0; i < n; i++) mq.push_back(cfg_data[i]);
            m_acc += n;
            m_words++;
          end
          if (mq.size() > 0) begin
            m_head = mq.pop_front();
            m_sh = 1;
            m_shifted++;
            if (m_shifted == int'(L)) m_mode = M_DONE;
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    m_busy = (m_mode != M_IDLE);
    m_done = (m_mode == M_DONE);
    m_ab   = (m_mode == M_ABORT);
  endtask

  // One clock: inputs already driven at the current negedge.
  task automatic cycle();
    check("cfg_ready", cfg_ready, model_ready());
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("shift_en", ccff_shift_en, m_sh);
    check("head", ccff_head, m_head);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("aborted", aborted, m_ab);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, cfg_ready, 0);
    check({tag, "_head"}, ccff_head, 0);
    check({tag, "_shift_en"}, ccff_shift_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_aborted"}, aborted, 0);
  endtask

  // stall_mode: 0 valid always, 1 three-cycle drop after word 2, 2 random.
  task automatic run_load(input int stall_mode, input int abort_at, input int reset_at);
    logic [W-1:0] words [NW];
    logic [W-1:0] wtmp;
    logic [63:0]  exp_bits, got_bits;
    int hidx, obs, gaps, dones, aborts, drop, cyc;
    bit rdy, abort_sent, was_reset;
    for (int i = 0; i < int'(NW); i++) words[i] = W'($urandom);
    exp_bits = '0;
    for (int k = 0; k < int'(L); k++) begin
      wtmp = words[k / W];
      exp_bits[k] = wtmp[k % W];
    end
    got_bits = '0;
    hidx = 0; obs = 0; gaps = 0; dones = 0; aborts = 0; drop = 0; cyc = 0;
    abort_sent = 0; was_reset = 0;

    start = 1; cfg_valid = 0; abort = 0;
    cycle();
    start = 0;

    while (m_mode == M_SHIFT) begin
      if (reset_at >= 0 && m_shifted == reset_at) begin
        #2 Reset = 0;
        #1 check_all_zero("async_reset");
        model_reset();
        start = 0; abort = 0; cfg_valid = 0;
        @(negedge clk);
        Reset = 1;
        was_reset = 1;
        break;
      end
      if (cyc > 1000) begin
        check("load_timeout", 1, 0);
        break;
      end
      cyc++;
      rdy = model_ready();
      cfg_data = words[(hidx < int'(NW)) ? hidx : int'(NW) - 1];
      case (stall_mode)
        0: cfg_valid = 1;
        1: begin
          cfg_valid = 1;
          if (hidx == 3 && rdy && drop < 3) begin
            cfg_valid = 0;
            drop++;
          end
        end
        default: cfg_valid = ($urandom_range(0, 2) != 0);
      endcase
      abort = 0;
      if (abort_at >= 0 && !abort_sent && m_shifted == abort_at) begin
        abort = 1;
        abort_sent = 1;
      end
      start = ($urandom_range(0, 5) == 0);
      if (rdy && cfg_valid && !abort) hidx++;
      cycle();
      if (ccff_shift_en) begin
        if (obs < 64) got_bits[obs] = ccff_head;
        obs++;
      end else if (obs > 0 && obs < int'(L)) begin
        gaps++;
      end
      if (done) dones++;
      if (aborted) aborts++;
    end

    if (!was_reset) begin
      start = 0; abort = 0; cfg_valid = 0;
      cycle();
      if (abort_at < 0) begin
        check("shift_count", obs, L);
        check("stream_bits", got_bits, exp_bits);
        check("done_pulses", dones, 1);
        check("abort_pulses", aborts, 0);
        if (stall_mode == 0) check("gaps_b2b", gaps, 0);
        if (stall_mode == 1) check("gaps_drop", gaps, 3);
      end else begin
        check("abort_shift_count", obs, abort_at);
        check("abort_pulses", aborts, 1);
        check("abort_no_done", dones, 0);
      end
    end
  endtask

  task automatic run_small();
    logic [7:0] sbits;
    int scnt, sdone, rdy_cnt;
    sbits = '0; scnt = 0; sdone = 0; rdy_cnt = 0;
    @(negedge clk);
    start_s = 1;
    @(negedge clk);
    start_s = 0; valid_s = 1; data_s = 8'hA5;
    for (int c = 0; c < 20; c++) begin
      if (ready_s) rdy_cnt++;
      @(negedge clk);
      if (shift_s) begin
        if (scnt < 8) sbits[scnt] = head_s;
        scnt++;
      end
      if (done_s) sdone++;
    end
    valid_s = 0;
    check("small_bits", sbits, 8'b0000_0101);
    check("small_count", scnt, 5);
    check("small_done", sdone, 1);
    check("small_ready_cycles", rdy_cnt, 1);
    check("small_busy_end", busy_s, 0);
  endtask

  initial begin
    Reset = 0; start = 0; abort = 0; cfg_valid = 0; cfg_data = '0;
    start_s = 0; abort_s = 0; valid_s = 0; data_s = '0;
    model_reset();
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);
    Reset = 1;

    abort = 1;
    cycle();
    cycle();
    abort = 0;

    run_load(0, -1, -1);
    run_load(1, -1, -1);
    for (int r = 0; r < 4; r++) run_load(2, -1, -1);
    run_load(0, 20, -1);
    run_load(0, int'(L) - 1, -1);
    run_load(2, -1, 25);
    run_load(0, -1, -1);
    run_small();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
